// File: rtl/msg_schedule_feeder.sv
// SHA-1 message-schedule feeder: accepts a padded 512-bit block and streams
// W[0..79] to the rounds engine, expanding in place in a 16-word ring.
module msg_schedule_feeder #(
  parameter int NUM_ROUNDS = 80,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  blk_valid,
  input  logic [16*WORD_W-1:0]  blk_data,
  output logic                  blk_ready,
  input  logic                  sched_clr,
  input  logic                  w_stall,
  output logic                  rounds_en,
  output logic [7:0]            rounds_cnt,
  output logic [WORD_W-1:0]     w_t,
  input  logic                  rounds_done,
  output logic                  sched_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] wbuf_q [16];
  logic [WORD_W-1:0] wbuf_d [16];

  logic              en_d;
  logic [7:0]        cnt_d;
  logic [WORD_W-1:0] w_d;

  logic [7:0]        t_nxt;
  logic [3:0]        ti, i13, i8, i2;
  logic [WORD_W-1:0] x, w_new;

  // Ring taps for W[t-3], W[t-8], W[t-14], W[t-16] of the next round.
  assign t_nxt = rounds_cnt + 8'd1;
  assign ti    = t_nxt[3:0];
  assign i13   = ti + 4'd13;
  assign i8    = ti + 4'd8;
  assign i2    = ti + 4'd2;
  assign x     = wbuf_q[i13] ^ wbuf_q[i8] ^ wbuf_q[i2] ^ wbuf_q[ti];
  assign w_new = (t_nxt < 8'd16) ? wbuf_q[ti]
                                 : {x[WORD_W-2:0], x[WORD_W-1]};

  assign blk_ready  = rst_n && (state_q == IDLE);
  assign sched_busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    wbuf_d  = wbuf_q;
    en_d    = rounds_en;
    cnt_d   = rounds_cnt;
    w_d     = w_t;
    if (sched_clr) begin
      state_d = IDLE;
      en_d    = 1'b0;
      cnt_d   = 8'd0;
      w_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++)
              wbuf_d[i] = blk_data[(15-i)*WORD_W +: WORD_W];
            en_d    = 1'b1;
            cnt_d   = 8'd0;
            w_d     = blk_data[15*WORD_W +: WORD_W];
            state_d = RUN;
          end
        end
        RUN: begin
          if (!w_stall) begin
            if (rounds_cnt == 8'(NUM_ROUNDS-1)) begin
              state_d = WAIT_DONE;
              en_d    = 1'b0;
            end else begin
              cnt_d      = t_nxt;
              w_d        = w_new;
              wbuf_d[ti] = w_new;
            end
          end
        end
        WAIT_DONE: begin
          if (rounds_done) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            w_d     = '0;
          end
        end
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
          cnt_d   = 8'd0;
          w_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rounds_en  <= 1'b0;
      rounds_cnt <= 8'd0;
      w_t        <= '0;
      for (int i = 0; i < 16; i++)
        wbuf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rounds_en  <= en_d;
      rounds_cnt <= cnt_d;
      w_t        <= w_d;
      for (int i = 0; i < 16; i++)
        wbuf_q[i] <= wbuf_d[i];
    end
  end

endmodule

// File: tb/tb_msg_schedule_feeder.sv
// Randomized bench for msg_schedule_feeder against a plain SHA-1
// W[0..79] expansion model.
module tb_msg_schedule_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic         sched_clr;
  logic         w_stall;
  logic         rounds_en;
  logic [7:0]   rounds_cnt;
  logic [31:0]  w_t;
  logic         rounds_done;
  logic         sched_busy;

  int n_cmp = 0;
  int n_bad = 0;

  msg_schedule_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid   (blk_valid),
    .blk_data    (blk_data),
    .blk_ready   (blk_ready),
    .sched_clr   (sched_clr),
    .w_stall     (w_stall),
    .rounds_en   (rounds_en),
    .rounds_cnt  (rounds_cnt),
    .w_t         (w_t),
    .rounds_done (rounds_done),
    .sched_busy  (sched_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mw [80];
  int          stall_len [80];
  int          done_at, clr_at, nv_at;
  logic [511:0] nv_data;
  int          obs_cnt [$];
  logic [31:0] obs_w [$];
  logic        obs_rdy [$];
  int          exp_cnt [$];
  logic [31:0] exp_w [$];
  bit          timed_out;

  function automatic void model_expand(input logic [511:0] b);
    logic [31:0] x;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) mw[t] = b[511-32*t -: 32];
      else begin
        x = mw[t-3] ^ mw[t-8] ^ mw[t-14] ^ mw[t-16];
        mw[t] = {x[30:0], x[31]};
      end
    end
  endfunction

  function automatic void build_exp(input int last);
    exp_cnt.delete();
    exp_w.delete();
    for (int t = 0; t <= last; t++)
      for (int k = 0; k <= stall_len[t]; k++) begin
        exp_cnt.push_back(t);
        exp_w.push_back(mw[t]);
      end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic clear_cfg();
    for (int t = 0; t < 80; t++) stall_len[t] = 0;
    done_at = -1; clr_at = -1; nv_at = -1;
  endtask

  task automatic feed(input logic [511:0] b, output bit ok);
    int g = 0;
    blk_valid = 1'b1;
    blk_data  = b;
    while (blk_ready !== 1'b1 && g < 300) begin
      @(negedge clk); g++;
    end
    ok = (blk_ready === 1'b1);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // Observes each cycle at the negedge while rounds_en is high; drives
  // stall/done/clr/next-valid for the following edge from the config.
  task automatic run_rounds();
    int last = -1;
    int rem = 0;
    int cyc = 0;
    obs_cnt.delete(); obs_w.delete(); obs_rdy.delete();
    timed_out = 0;
    while (rounds_en === 1'b1) begin
      obs_cnt.push_back(int'(rounds_cnt));
      obs_w.push_back(w_t);
      obs_rdy.push_back(blk_ready);
      if (int'(rounds_cnt) != last) begin
        last = int'(rounds_cnt);
        rem  = (last < 80) ? stall_len[last] : 0;
        sched_clr = (last == clr_at);
      end else sched_clr = 1'b0;
      w_stall = (rem > 0);
      if (rem > 0) rem--;
      rounds_done = (last == done_at);
      if (nv_at >= 0 && last >= nv_at) begin
        blk_valid = 1'b1; blk_data = nv_data;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 500) begin timed_out = 1; break; end
    end
    w_stall = 0; rounds_done = 0; sched_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; blk_valid = 0; blk_data = '0; sched_clr = 0;
    w_stall = 0; rounds_done = 0;
    clear_cfg();
    @(negedge clk);
    n_cmp++;
    if ({blk_ready, rounds_en, rounds_cnt, w_t, sched_busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b en=%b cnt=%0d w=%h busy=%b want all 0",
               blk_ready, rounds_en, rounds_cnt, w_t, sched_busy);
    end
    rst_n = 1;
    #1;
    n_cmp++;
    if (blk_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", blk_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_abc();
    logic [511:0] b = '0;
    bit ok;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    clear_cfg();
    model_expand(b);
    feed(b, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL abc_accept got ready timeout want accept"); end
    run_rounds();
    build_exp(79);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++;
      $display("FAIL abc_len got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
      n_cmp++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL abc_seq[%0d] got cnt=%0d w=%h want cnt=%0d w=%h",
                 i, obs_cnt[i], obs_w[i], exp_cnt[i], exp_w[i]);
      end
    end
    if (obs_w.size() >= 20) begin
      n_cmp++;
      if (obs_w[0] !== 32'h61626380 || obs_w[16] !== 32'hC2C4C700 ||
          obs_w[17] !== 32'h0 || obs_w[18] !== 32'h00000030 ||
          obs_w[19] !== 32'h85898E01) begin
        n_bad++;
        $display("FAIL abc_known got %h %h %h %h %h want 61626380 c2c4c700 0 30 85898e01",
                 obs_w[0], obs_w[16], obs_w[17], obs_w[18], obs_w[19]);
      end
    end
    n_cmp++;
    if (rounds_en !== 0 || rounds_cnt !== 8'd79 || sched_busy !== 1 || blk_ready !== 0) begin
      n_bad++;
      $display("FAIL abc_wait got en=%b cnt=%0d busy=%b rdy=%b want 0 79 1 0",
               rounds_en, rounds_cnt, sched_busy, blk_ready);
    end
    rounds_done = 1; @(negedge clk); rounds_done = 0;
    n_cmp++;
    if (sched_busy !== 0 || rounds_cnt !== 8'd0 || blk_ready !== 1) begin
      n_bad++;
      $display("FAIL abc_idle got busy=%b cnt=%0d rdy=%b want 0 0 1",
               sched_busy, rounds_cnt, blk_ready);
    end
  endtask

  task automatic test_stall();
    logic [511:0] b;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      clear_cfg();
      if (pass == 0) begin
        b = '0; b[511:480] = 32'h61626380; b[31:0] = 32'h18;
        stall_len[15] = 5; stall_len[79] = 3;
      end else begin
        b = rand_block();
        stall_len[0] = $urandom_range(1, 4);
        for (int k = 0; k < 6; k++) stall_len[$urandom_range(1, 79)] = $urandom_range(1, 6);
      end
      model_expand(b);
      feed(b, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL stall_accept pass %0d got timeout want accept", pass); end
      run_rounds();
      build_exp(79);
      n_cmp++;
      if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
        n_bad++;
        $display("FAIL stall_active pass %0d got %0d want %0d", pass, obs_cnt.size(), exp_cnt.size());
      end
      if (pass == 0) begin
        n_cmp++;
        if (obs_cnt.size() != 88) begin
          n_bad++; $display("FAIL stall_88 got %0d want 88", obs_cnt.size());
        end
      end
      for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
        n_cmp++;
        if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i]) begin
          n_bad++;
          $display("FAIL stall_seq p%0d[%0d] got cnt=%0d w=%h want cnt=%0d w=%h",
                   pass, i, obs_cnt[i], obs_w[i], exp_cnt[i], exp_w[i]);
        end
      end
      rounds_done = 1; @(negedge clk); rounds_done = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1 = rand_block();
    logic [511:0] b2 = rand_block();
    bit ok;
    clear_cfg();
    nv_at = 10; nv_data = b2;
    model_expand(b1);
    feed(b1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_accept1 got timeout want accept"); end
    run_rounds();
    build_exp(79);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++; $display("FAIL b2b_len1 got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
      n_cmp++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i] || obs_rdy[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_seq1[%0d] got cnt=%0d w=%h rdy=%b want cnt=%0d w=%h rdy=0",
                 i, obs_cnt[i], obs_w[i], obs_rdy[i], exp_cnt[i], exp_w[i]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sched_busy !== 1 || blk_ready !== 0 || rounds_en !== 0) begin
        n_bad++;
        $display("FAIL b2b_wait got busy=%b rdy=%b en=%b want 1 0 0", sched_busy, blk_ready, rounds_en);
      end
      @(negedge clk);
    end
    rounds_done = 1; @(negedge clk); rounds_done = 0;
    n_cmp++;
    if (blk_ready !== 1 || rounds_en !== 0) begin
      n_bad++; $display("FAIL b2b_idle got rdy=%b en=%b want 1 0", blk_ready, rounds_en);
    end
    clear_cfg();
    model_expand(b2);
    feed(b2, ok);
    run_rounds();
    build_exp(79);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++; $display("FAIL b2b_len2 got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
      n_cmp++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL b2b_seq2[%0d] got cnt=%0d w=%h want cnt=%0d w=%h",
                 i, obs_cnt[i], obs_w[i], exp_cnt[i], exp_w[i]);
      end
    end
    rounds_done = 1; @(negedge clk); rounds_done = 0;
  endtask

  task automatic test_clear();
    logic [511:0] b = rand_block();
    bit ok;
    clear_cfg();
    clr_at = 50;
    model_expand(b);
    feed(b, ok);
    run_rounds();
    build_exp(50);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++; $display("FAIL clr_len got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    n_cmp++;
    if (rounds_en !== 0 || rounds_cnt !== 0 || w_t !== 0 || sched_busy !== 0 || blk_ready !== 1) begin
      n_bad++;
      $display("FAIL clr_run got en=%b cnt=%0d w=%h busy=%b rdy=%b want 0 0 0 0 1",
               rounds_en, rounds_cnt, w_t, sched_busy, blk_ready);
    end
    b = rand_block();
    clear_cfg();
    model_expand(b);
    feed(b, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL clr_accept got timeout want accept"); end
    run_rounds();
    build_exp(79);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++; $display("FAIL clr_len2 got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
      n_cmp++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL clr_seq[%0d] got cnt=%0d w=%h want cnt=%0d w=%h",
                 i, obs_cnt[i], obs_w[i], exp_cnt[i], exp_w[i]);
      end
    end
    sched_clr = 1; rounds_done = 1; blk_valid = 1;
    @(negedge clk);
    sched_clr = 0; rounds_done = 0; blk_valid = 0;
    n_cmp++;
    if (rounds_en !== 0 || rounds_cnt !== 0 || sched_busy !== 0 || blk_ready !== 1) begin
      n_bad++;
      $display("FAIL clr_wait got en=%b cnt=%0d busy=%b rdy=%b want 0 0 0 1",
               rounds_en, rounds_cnt, sched_busy, blk_ready);
    end
  endtask

  task automatic test_done_in_run();
    logic [511:0] b = rand_block();
    bit ok;
    clear_cfg();
    done_at = $urandom_range(5, 70);
    model_expand(b);
    feed(b, ok);
    run_rounds();
    build_exp(79);
    n_cmp++;
    if (timed_out || obs_cnt.size() != exp_cnt.size()) begin
      n_bad++; $display("FAIL done_run_len got %0d want %0d", obs_cnt.size(), exp_cnt.size());
    end
    for (int i = 0; i < exp_cnt.size() && i < obs_cnt.size(); i++) begin
      n_cmp++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL done_run_seq[%0d] got cnt=%0d w=%h want cnt=%0d w=%h",
                 i, obs_cnt[i], obs_w[i], exp_cnt[i], exp_w[i]);
      end
    end
    n_cmp++;
    if (sched_busy !== 1 || rounds_cnt !== 8'd79) begin
      n_bad++; $display("FAIL done_run_wait got busy=%b cnt=%0d want 1 79", sched_busy, rounds_cnt);
    end
    rounds_done = 1; @(negedge clk); rounds_done = 0;
  endtask

  task automatic test_reset_mid_run();
    logic [511:0] b = rand_block();
    bit ok;
    int g = 0;
    clear_cfg();
    feed(b, ok);
    while (rounds_cnt !== 8'd37 && g < 200) begin @(negedge clk); g++; end
    n_cmp++;
    if (rounds_cnt !== 8'd37) begin
      n_bad++; $display("FAIL rst_reach got cnt=%0d want 37", rounds_cnt);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (rounds_en !== 0 || rounds_cnt !== 0 || w_t !== 0 || sched_busy !== 0 || blk_ready !== 0) begin
      n_bad++;
      $display("FAIL rst_async got en=%b cnt=%0d w=%h busy=%b rdy=%b want all 0",
               rounds_en, rounds_cnt, w_t, sched_busy, blk_ready);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++;
    if (blk_ready !== 1 || rounds_en !== 0) begin
      n_bad++; $display("FAIL rst_release got rdy=%b en=%b want 1 0", blk_ready, rounds_en);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_clear();
    test_done_in_run();
    test_reset_mid_run();
    test_abc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
